// File: rtl/hex_display_scanner_pkg.sv
// hex_display_pkg: shared digit count, slot-state enum and one-hot helper for the display scanner
package hex_display_pkg;
  localparam int NUM_DIGITS = 4;
  typedef enum logic {DEAD, DRIVE} slot_state_t;
  function automatic logic [NUM_DIGITS-1:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction
endpackage

// File: rtl/hex_display_scanner_prescaler.sv
// scan_prescaler: slot counter, end-of-slot strobe and dead-time/drive state
module scan_prescaler
  import hex_display_pkg::*;
#(
  parameter int REFRESH_DIV = 1000,
  parameter int DEAD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        wrap,
  output slot_state_t state
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] DLAST = CW'(DEAD_CYCLES > 0 ? DEAD_CYCLES - 1 : 0);
  // With no dead time the slot never leaves DRIVE, so that is also the slot-start state
  localparam slot_state_t START = DEAD_CYCLES == 0 ? DRIVE : DEAD;
  logic [CW-1:0] cnt;
  slot_state_t state_nxt;
  assign wrap = cnt == LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      state <= START;
    end else begin
      cnt <= wrap ? '0 : cnt + CW'(1);
      state <= state_nxt;
    end
  always_comb begin
    state_nxt = state;
    if (wrap) state_nxt = START;
    else if (state == DEAD && cnt == DLAST) state_nxt = DRIVE;
  end
endmodule

// File: rtl/hex_display_scanner.sv
// hex_display_scanner: 4-digit multiplexed hex display scanner with frame-synchronous double-buffered value
module hex_display_scanner
  import hex_display_pkg::*;
#(
  parameter int REFRESH_DIV = 1000,
  parameter int DEAD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        blank_lz,
  output logic [3:0]  nibble,
  output logic        blank,
  output logic [3:0]  digit_en,
  output logic        scan_tick
);
  logic wrap, frame, pend_flag, lz;
  logic [1:0] idx;
  logic [15:0] pend_val, act_val;
  slot_state_t state;
  scan_prescaler #(.REFRESH_DIV(REFRESH_DIV), .DEAD_CYCLES(DEAD_CYCLES)) u_pre (
    .clk(clk),
    .rst_n(rst_n),
    .wrap(wrap),
    .state(state)
  );
  assign frame = wrap && idx == 2'd3;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      pend_val <= '0;
      pend_flag <= 1'b0;
      act_val <= '0;
      lz <= 1'b0;
    end else begin
      lz <= blank_lz;
      if (wrap) idx <= idx + 2'd1;
      if (load) pend_val <= value;
      pend_flag <= !frame && (load || pend_flag);
      // A load landing on the boundary itself bypasses the pending buffer
      if (frame) act_val <= load ? value : pend_flag ? pend_val : act_val;
    end
  assign scan_tick = wrap;
  assign digit_en = state == DRIVE ? onehot4(idx) : 4'b0000;
  assign nibble = act_val[4*idx +: 4];
  assign blank = lz && idx != 2'd0 && (act_val >> {idx, 2'b00}) == 16'h0000;
endmodule

// File: tb/tb_hex_display_scanner.sv
// tb_hex_display_scanner: scoreboard and table-driven checks of scan timing, double buffering and blanking
module tb_hex_display_scanner;
  localparam int R = 8;
  localparam int D = 2;
  logic clk = 0, rst_n = 1, load = 0, blank_lz = 0;
  logic [15:0] value = 0;
  logic [3:0] nibble, digit_en;
  logic blank, scan_tick;
  int checks = 0, errors = 0;
  typedef struct packed {logic [3:0] de; logic [3:0] nib; logic bl; logic tk;} exp_t;
  typedef struct packed {logic [15:0] val; logic lz; logic [3:0] exp_blank;} vec_t;
  exp_t q[$];
  int m_c;
  logic [15:0] m_act, m_pend;
  logic m_pf, m_lz;

  hex_display_scanner #(.REFRESH_DIV(R), .DEAD_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .blank_lz(blank_lz),
    .nibble(nibble), .blank(blank), .digit_en(digit_en), .scan_tick(scan_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, m_c, got, exp);
    end
  endtask

  function automatic exp_t exp_of(input int c, input logic [15:0] act, input logic lz);
    int i, ph;
    exp_t e;
    i = (c / R) % 4;
    ph = c % R;
    e.de = ph >= D ? 4'(1 << i) : 4'h0;
    e.nib = 4'(act >> (4 * i));
    e.bl = lz && i != 0 && (act >> (4 * i)) == 16'h0;
    e.tk = ph == R - 1;
    return e;
  endfunction

  task automatic cyc(input logic ld, input logic [15:0] v);
    exp_t e;
    logic fr;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard @cycle %0d: no expected entry queued", m_c);
    end else begin
      e = q.pop_front();
      chk("digit_en", 16'(digit_en), 16'(e.de));
      chk("nibble", 16'(nibble), 16'(e.nib));
      chk("blank", 16'(blank), 16'(e.bl));
      chk("scan_tick", 16'(scan_tick), 16'(e.tk));
    end
    load = ld;
    value = v;
    fr = (m_c % R == R - 1) && ((m_c / R) % 4 == 3);
    if (fr) begin
      m_act = ld ? v : m_pf ? m_pend : m_act;
      m_pf = 0;
    end else if (ld) m_pf = 1;
    if (ld) m_pend = v;
    m_lz = blank_lz;
    m_c++;
    q.push_back(exp_of(m_c, m_act, m_lz));
    @(negedge clk);
    load = 0;
  endtask

  task automatic run_to(input int c);
    while (m_c < c) cyc(1'b0, 16'h0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " digit_en"}, 16'(digit_en), 16'h0);
    chk({tag, " nibble"}, 16'(nibble), 16'h0);
    chk({tag, " blank"}, 16'(blank), 16'h0);
    chk({tag, " scan_tick"}, 16'(scan_tick), 16'h0);
    chk({tag, " pend_flag"}, 16'(dut.pend_flag), 16'h0);
    chk({tag, " act_val"}, dut.act_val, 16'h0);
  endtask

  task automatic reset_release;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    m_c = 0;
    m_act = 0;
    m_pend = 0;
    m_pf = 0;
    m_lz = 0;
    q.delete();
    q.push_back(exp_of(0, 16'h0, 1'b0));
    @(negedge clk);
  endtask

  initial begin
    vec_t tbl[7];
    int target;
    tbl[0] = '{val: 16'h00A0, lz: 1'b1, exp_blank: 4'b1100};
    tbl[1] = '{val: 16'h0000, lz: 1'b1, exp_blank: 4'b1110};
    tbl[2] = '{val: 16'h00A0, lz: 1'b0, exp_blank: 4'b0000};
    tbl[3] = '{val: 16'h0000, lz: 1'b0, exp_blank: 4'b0000};
    tbl[4] = '{val: 16'h1A2F, lz: 1'b1, exp_blank: 4'b0000};
    tbl[5] = '{val: 16'h000F, lz: 1'b1, exp_blank: 4'b1110};
    tbl[6] = '{val: 16'h0100, lz: 1'b1, exp_blank: 4'b1000};
    m_c = 0;
    #1 rst_n = 0;
    #2 chk_reset("init");
    reset_release;
    run_to(2);
    chk("de c2", 16'(digit_en), 16'h1);
    run_to(5);
    cyc(1'b1, 16'h1A2F);
    run_to(10);
    chk("de c10", 16'(digit_en), 16'h2);
    run_to(31);
    chk("nib c31", 16'(nibble), 16'h0);
    chk("tick c31", 16'(scan_tick), 16'h1);
    run_to(36);
    chk("nib c36", 16'(nibble), 16'hF);
    run_to(40);
    cyc(1'b1, 16'h1111);
    run_to(44);
    chk("nib c44", 16'(nibble), 16'h2);
    run_to(50);
    cyc(1'b1, 16'h2222);
    run_to(52);
    chk("nib c52", 16'(nibble), 16'hA);
    run_to(60);
    chk("nib c60", 16'(nibble), 16'h1);
    run_to(68);
    chk("nib c68", 16'(nibble), 16'h2);
    run_to(95);
    cyc(1'b1, 16'h3333);
    chk("nib c96", 16'(nibble), 16'h3);
    chk("pend_flag c96", 16'(dut.pend_flag), 16'h0);
    run_to(130);
    for (int k = 0; k < 7; k++) begin
      blank_lz = tbl[k].lz;
      cyc(1'b1, tbl[k].val);
      target = (m_c / (4 * R) + 1) * 4 * R;
      for (int s = 0; s < 4; s++) begin
        run_to(target + R * s + R / 2);
        chk($sformatf("tbl%0d blank slot%0d", k, s), 16'(blank), 16'(tbl[k].exp_blank[s]));
      end
    end
    blank_lz = 0;
    #2 rst_n = 0;
    reset_release;
    run_to(3);
    cyc(1'b1, 16'hBEEF);
    run_to(20);
    #2 rst_n = 0;
    #1 chk_reset("midrst");
    reset_release;
    run_to(70);
    chk("nib after midrst", 16'(nibble), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
